mmm_iter: RTL and testbench

MMM_ITER -- requirements
Module: mmm_iter

---
 rtl/mmm_iter.sv | 128 ++++++++++++
 tb/tb_mmm_iter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmm_iter.sv
// Bit-serial Montgomery modular multiplier: R = A*B*2^-WIDTH mod M, one multiplier bit per cycle.
// Define MMM_FINAL_SUB_EN to add the conditional final subtraction (R < M); otherwise R < 2M.
module mmm_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH:0]   R,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH+1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   r_q;
    logic             busy_q, done_q, err_q;

    logic             bit_a, q_bit;
    logic [WIDTH+1:0] acc_sum, acc_step_d, acc_fin_d;

    // One Montgomery step; the sum stays below 2^(WIDTH+2) so nothing is lost before the shift.
    always_comb begin
        bit_a      = a_q[cnt_q];
        q_bit      = acc_q[0] ^ (bit_a & b_q[0]);
        acc_sum    = acc_q
                   + (bit_a ? {2'b00, b_q} : '0)
                   + (q_bit ? {2'b00, m_q} : '0);
        acc_step_d = acc_sum >> 1;
    end

`ifdef MMM_FINAL_SUB_EN
    always_comb begin
        acc_fin_d = acc_q;
        if (acc_q >= {2'b00, m_q}) begin
            acc_fin_d = acc_q - {2'b00, m_q};
        end
    end
`else
    assign acc_fin_d = acc_q;
`endif

    // abort outranks ena; ena=0 freezes everything else, including pending done/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= (state_q == ITER) || (state_q == SUB);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (M[0]) begin
                            a_q     <= A;
                            b_q     <= B;
                            m_q     <= M;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= ITER;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_q <= acc_step_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SUB: begin
                    acc_q   <= acc_fin_d;
                    state_q <= DONE;
                end
                DONE: begin
                    r_q     <= acc_q[WIDTH:0];
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign R           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mmm_iter.sv
// Directed bench for mmm_iter: a WIDTH=4 instance for timing/control scenarios and a
// WIDTH=8 instance checked against the Montgomery identity R*2^8 == A*B (mod M).
module tb_mmm_iter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;

    logic       start4 = 1'b0, abort4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, m4 = '0;
    logic [4:0] r4;
    logic       busy4, done4, err4;
    logic [1:0] st4;

    logic       start8 = 1'b0, abort8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, m8 = '0;
    logic [8:0] r8;
    logic       busy8, done8, err8;
    logic [1:0] st8;

    int checks = 0;
    int errors = 0;

    int         lat, busy_n, done_n, err_n;
    logic [4:0] res, res_end;

    mmm_iter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena), .start(start4), .abort(abort4),
        .A(a4), .B(b4), .M(m4), .R(r4), .busy(busy4), .done(done4), .err(err4),
        .dbg_state_o(st4)
    );

    mmm_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .start(start8), .abort(abort8),
        .A(a8), .B(b8), .M(m8), .R(r8), .busy(busy8), .done(done8), .err(err8),
        .dbg_state_o(st8)
    );

    always #5 clk = ~clk;

    // k=0 is the edge that samples start; every later edge k is sampled #1 after it.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                           input int start2_at, input int abort_at,
                           input int stall_at, input int stall_len);
        lat = -1; busy_n = 0; done_n = 0; err_n = 0; res = '0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 0) begin a4 = a; b4 = b; m4 = m; end
            if (k == 2) begin a4 = ~a; b4 = ~b; end
            start4 = (k == 0) || (k == start2_at);
            abort4 = (k == abort_at);
            ena    = !((k >= stall_at) && (k < stall_at + stall_len));
            @(posedge clk);
            #1;
            busy_n += int'(busy4);
            err_n  += int'(err4);
            if (done4) begin
                done_n++;
                if (lat < 0) begin lat = k; res = r4; end
            end
        end
        res_end = r4;
        @(negedge clk);
        start4 = 1'b0; abort4 = 1'b0; ena = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (r4 !== 5'd0) begin errors++; $display("FAIL reset_R got %0d want 0", r4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done4); end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err4); end
        checks++; if (st4 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st4); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op4(4'd1, 4'd1, 4'd13, -1, -1, -1, 0);
        checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", lat); end
        checks++; if (busy_n !== 5) begin errors++; $display("FAIL basic_busy_cycles got %0d want 5", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done_cycles got %0d want 1", done_n); end
        checks++; if (err_n !== 0) begin errors++; $display("FAIL basic_err got %0d want 0", err_n); end
        checks++; if (res !== 5'd9) begin errors++; $display("FAIL basic_R got %0d want 9", res); end
    endtask

    task automatic test_even_modulus();
        run_op4(4'd5, 4'd3, 4'd12, -1, -1, -1, 0);
        checks++; if (err_n !== 1) begin errors++; $display("FAIL even_err_cycles got %0d want 1", err_n); end
        checks++; if (busy_n !== 0) begin errors++; $display("FAIL even_busy got %0d want 0", busy_n); end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL even_done got %0d want 0", done_n); end
        checks++; if (res_end !== 5'd9) begin errors++; $display("FAIL even_R_kept got %0d want 9", res_end); end
    endtask

    task automatic test_vectors();
        logic [3:0] va [6];
        logic [3:0] vb [6];
        logic [3:0] vm [6];
        logic [4:0] ve [6];
        va = '{4'd3, 4'd8, 4'd12, 4'd0, 4'd14, 4'd1};
        vb = '{4'd5, 4'd8, 4'd12, 4'd7, 4'd14, 4'd1};
        vm = '{4'd11, 4'd9, 4'd13, 4'd15, 4'd15, 4'd13};
`ifdef MMM_FINAL_SUB_EN
        ve = '{5'd3, 5'd4, 5'd9, 5'd0, 5'd1, 5'd9};
`else
        ve = '{5'd3, 5'd4, 5'd9, 5'd0, 5'd16, 5'd9};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op4(va[i], vb[i], vm[i], -1, -1, -1, 0);
            checks++;
            if (res !== ve[i] || lat !== 6) begin
                errors++;
                $display("FAIL vector%0d got R=%0d lat=%0d want R=%0d lat=6", i, res, lat, ve[i]);
            end
        end
    endtask

    task automatic test_stall();
        run_op4(4'd1, 4'd1, 4'd13, 5, -1, 2, 3);
        checks++; if (lat !== 9) begin errors++; $display("FAIL stall_latency got %0d want 9", lat); end
        checks++; if (busy_n !== 8) begin errors++; $display("FAIL stall_busy got %0d want 8", busy_n); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL stall_done_count got %0d want 1", done_n); end
        checks++; if (res !== 5'd9) begin errors++; $display("FAIL stall_R got %0d want 9", res); end
    endtask

    task automatic test_done_hold();
        run_op4(4'd3, 4'd5, 4'd11, 6, -1, 7, 2);
        checks++; if (lat !== 6) begin errors++; $display("FAIL hold_latency got %0d want 6", lat); end
        checks++; if (done_n !== 3) begin errors++; $display("FAIL hold_done_samples got %0d want 3", done_n); end
        checks++; if (busy_n !== 5) begin errors++; $display("FAIL hold_busy got %0d want 5", busy_n); end
        checks++; if (res !== 5'd3) begin errors++; $display("FAIL hold_R got %0d want 3", res); end
    endtask

    task automatic test_abort();
        run_op4(4'd1, 4'd1, 4'd13, -1, 2, -1, 0);
        checks++; if (done_n !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_n); end
        checks++; if (busy_n !== 1) begin errors++; $display("FAIL abort_busy got %0d want 1", busy_n); end
        checks++; if (res_end !== 5'd3) begin errors++; $display("FAIL abort_R_kept got %0d want 3", res_end); end
        run_op4(4'd1, 4'd1, 4'd13, -1, 0, -1, 0);
        checks++; if (busy_n !== 0 || done_n !== 0) begin
            errors++; $display("FAIL abort_with_start got busy=%0d done=%0d want 0 0", busy_n, done_n);
        end
        run_op4(4'd1, 4'd1, 4'd13, -1, 3, 3, 2);
        checks++; if (busy_n !== 2 || done_n !== 0) begin
            errors++; $display("FAIL abort_over_ena got busy=%0d done=%0d want 2 0", busy_n, done_n);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd12; m4 = 4'd13; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (r4 !== 5'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || err4 !== 1'b0 || st4 !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got R=%0d busy=%b done=%b err=%b st=%0d want all 0",
                     r4, busy4, done4, err4, st4);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op4(4'd3, 4'd5, 4'd11, -1, -1, -1, 0);
        checks++; if (lat !== 6 || done_n !== 1 || res !== 5'd3) begin
            errors++;
            $display("FAIL rst_then_op got lat=%0d done=%0d R=%0d want 6 1 3", lat, done_n, res);
        end
    endtask

    task automatic test_width8();
        longint av, bv, mv, rv;
        int     l8;
        for (int n = 0; n < 150; n++) begin
            if (n == 0) begin mv = 255; av = 254; bv = 254; end
            else if (n == 1) begin mv = 3; av = 2; bv = 1; end
            else begin
                mv = 2 * longint'($urandom_range(1, 127)) + 1;
                av = longint'($urandom_range(0, int'(mv) - 1));
                bv = longint'($urandom_range(0, int'(mv) - 1));
            end
            @(negedge clk);
            a8 = av[7:0]; b8 = bv[7:0]; m8 = mv[7:0]; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            l8 = -1;
            rv = 0;
            for (int k = 1; k < 20 && l8 < 0; k++) begin
                @(posedge clk);
                #1;
                if (done8) begin l8 = k; rv = longint'(r8); end
            end
            checks++;
`ifdef MMM_FINAL_SUB_EN
            if (l8 !== 10 || ((rv * 256) % mv) != ((av * bv) % mv) || rv >= mv) begin
`else
            if (l8 !== 10 || ((rv * 256) % mv) != ((av * bv) % mv) || rv >= 2 * mv) begin
`endif
                errors++;
                $display("FAIL w8_vector A=%0d B=%0d M=%0d got R=%0d lat=%0d", av, bv, mv, rv, l8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_even_modulus();
        test_vectors();
        test_stall();
        test_done_hold();
        test_abort();
        test_reset_mid();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
